// File: rtl/tea_decryptor_core.sv
// Fully unrolled TEA decryption pipeline: one input capture register, then 32 round stages, one block per clock.
// Optional macro TEA_DEC_OUT_REG_EN adds one output register after the last round (latency 33 instead of 32).
module tea_decryptor_core #(
   parameter logic [31:0] DELTA = 32'h9E3779B9
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [127:0] key,
   input  logic [63:0]  textI,
   input  logic         textI_vld,
   output logic [63:0]  textO,
   output logic         textO_vld
);

   localparam int NumRounds = 32;

   logic [31:0] k0, k1, k2, k3;
   assign {k0, k1, k2, k3} = key;

   // Index 0 holds the raw ciphertext; index r+1 holds the block after decryption round r.
   logic [63:0] stageText_q [0:NumRounds];
   logic        stageVld_q  [0:NumRounds];
   logic [63:0] stageText_d [0:NumRounds-1];

   for (genvar r = 0; r < NumRounds; r++) begin : gRound
      localparam logic [31:0] RoundSum = 32'(DELTA * 32'(NumRounds - r));

      logic [31:0] v0, v1, v1New, v0New;

      assign v0    = stageText_q[r][63:32];
      assign v1    = stageText_q[r][31:0];
      assign v1New = v1 - (((v0 << 4) + k2) ^ (v0 + RoundSum) ^ ((v0 >> 5) + k3));
      assign v0New = v0 - (((v1New << 4) + k0) ^ (v1New + RoundSum) ^ ((v1New >> 5) + k1));
      assign stageText_d[r] = {v0New, v1New};
   end

   // Data advances every cycle regardless of valid; only the valid bits decide what is emitted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s <= NumRounds; s++) begin
            stageText_q[s] <= '0;
            stageVld_q[s]  <= 1'b0;
         end
      end else begin
         stageText_q[0] <= textI;
         stageVld_q[0]  <= textI_vld;
         for (int s = 0; s < NumRounds; s++) begin
            stageText_q[s+1] <= stageText_d[s];
            stageVld_q[s+1]  <= stageVld_q[s];
         end
      end
   end

`ifdef TEA_DEC_OUT_REG_EN
   logic [63:0] outText_q;
   logic        outVld_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outText_q <= '0;
         outVld_q  <= 1'b0;
      end else begin
         outText_q <= stageText_q[NumRounds];
         outVld_q  <= stageVld_q[NumRounds];
      end
   end

   assign textO     = outText_q;
   assign textO_vld = outVld_q;
`else
   assign textO     = stageText_q[NumRounds];
   assign textO_vld = stageVld_q[NumRounds];
`endif

endmodule

// File: tb/tb_tea_decryptor_core.sv
// Scoreboard bench for tea_decryptor_core: random traffic checked against a loop-based TEA reference model.
module tb_tea_decryptor_core;

   localparam logic [31:0] Delta = 32'h9E3779B9;
`ifdef TEA_DEC_OUT_REG_EN
   localparam int Latency = 33;
`else
   localparam int Latency = 32;
`endif

   logic         clk = 1'b0;
   logic         resetn;
   logic [127:0] key;
   logic [63:0]  textI;
   logic         textI_vld;
   logic [63:0]  textO;
   logic         textO_vld;

   always #5 clk = ~clk;

   tea_decryptor_core #(.DELTA(Delta)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .key       (key),
      .textI     (textI),
      .textI_vld (textI_vld),
      .textO     (textO),
      .textO_vld (textO_vld)
   );

   typedef struct {
      logic [63:0] data;
      longint      due;
   } expEntry_t;

   expEntry_t sb[$];
   longint    cycleCnt = 0;
   int        nChecks  = 0;
   int        nFails   = 0;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Textbook TEA: running sum, 32 iterations.
   function automatic logic [63:0] teaEncrypt(input logic [63:0] p, input logic [127:0] k);
      logic [31:0] v0, v1, sum;
      v0  = p[63:32];
      v1  = p[31:0];
      sum = 32'd0;
      for (int i = 0; i < 32; i++) begin
         sum = sum + Delta;
         v0  = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
         v1  = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
      end
      return {v0, v1};
   endfunction

   function automatic logic [63:0] teaDecrypt(input logic [63:0] c, input logic [127:0] k);
      logic [31:0] v0, v1, sum;
      v0  = c[63:32];
      v1  = c[31:0];
      sum = Delta << 5;
      for (int i = 0; i < 32; i++) begin
         v1  = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
         v0  = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
         sum = sum - Delta;
      end
      return {v0, v1};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   task automatic applyStimulus(input logic [63:0] ct, input logic v, input logic [63:0] expPlain);
      expEntry_t e;
      @(negedge clk);
      textI     = ct;
      textI_vld = v;
      if (v) begin
         e.data = expPlain;
         e.due  = cycleCnt + 1 + Latency;
         sb.push_back(e);
      end
   endtask

   task automatic applyIdle();
      applyStimulus(64'd0, 1'b0, 64'd0);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < Latency + 10; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL %s drain: %0d blocks still pending, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Monitor: every presented output must match the oldest pending block in data and in cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due < cycleCnt) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL missingOutput: textO_vld=0 at cycle %0d, expected block %h", sb[0].due, sb[0].data);
         void'(sb.pop_front());
      end
      if (textO_vld === 1'b1) begin
         if (sb.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpectedValid: textO_vld=1 with data %h at cycle %0d, expected 0", textO, cycleCnt);
         end else if (sb[0].due != cycleCnt) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL outputTiming: valid at cycle %0d, expected at cycle %0d", cycleCnt, sb[0].due);
         end else begin
            checkOutput("outputData", textO, sb[0].data);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      logic [63:0]  p, ct;
      logic [127:0] rk;
      logic         pat [7];
      longint       target;

      resetn    = 1'b0;
      key       = '0;
      textI     = '0;
      textI_vld = 1'b0;
      pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("resetVld", {63'd0, textO_vld}, 64'd0);
         checkOutput("resetText", textO, 64'd0);
      end
      @(negedge clk);
      resetn = 1'b1;

      $display("[TB] known vector, key=0");
      key = '0;
      applyStimulus(64'h41EA3A0A_94BAA940, 1'b1, 64'h0);
      applyIdle();
      waitDrain("knownVector");

      $display("[TB] 100 back-to-back blocks, key=AB..AB");
      key = {16{8'hAB}};
      for (int i = 0; i < 100; i++) begin
         p = {$urandom, $urandom};
         applyStimulus(teaEncrypt(p, key), 1'b1, p);
      end
      applyIdle();
      waitDrain("burst100");

      $display("[TB] valid pattern 1,0,0,1,1,0,1");
      key = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 7; i++) begin
         ct = {$urandom, $urandom};
         applyStimulus(ct, pat[i], teaDecrypt(ct, key));
      end
      applyIdle();
      waitDrain("validPattern");

      $display("[TB] random traffic");
      key = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 150; i++) begin
         p = {$urandom, $urandom};
         applyStimulus(teaEncrypt(p, key), 1'($urandom_range(0, 1)), p);
      end
      applyIdle();
      waitDrain("randomTraffic");

      $display("[TB] asynchronous reset with blocks in flight");
      rk  = {$urandom, $urandom, $urandom, $urandom};
      key = rk;
      for (int i = 0; i < 12; i++) begin
         ct = {$urandom, $urandom};
         applyStimulus(ct, 1'b1, teaDecrypt(ct, rk));
      end
      applyIdle();
      target = sb[1].due;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #2;
         if (cycleCnt >= target) break;
      end
      checkOutput("preResetVld", {63'd0, textO_vld}, 64'd1);
      resetn = 1'b0;
      #1;
      checkOutput("asyncResetVld", {63'd0, textO_vld}, 64'd0);
      checkOutput("asyncResetText", textO, 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      ct = {$urandom, $urandom};
      applyStimulus(ct, 1'b1, teaDecrypt(ct, rk));
      applyIdle();
      repeat (Latency + 15) @(negedge clk);
      waitDrain("postReset");

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/tea_decryptor_core.md
TEA_DECRYPTOR_CORE -- requirements
Module: tea_decryptor_core

Interface
REQ-001 Parameter DELTA, default 32'h9E3779B9, the TEA round constant.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 key  input  128  key; k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0].
REQ-005 textI  input  64  ciphertext block; v0=textI[63:32], v1=textI[31:0].
REQ-006 textI_vld  input  1  textI valid in this cycle; no ready/back-pressure exists.
REQ-007 textO  output  64  plaintext block; {v0,v1}, same packing as textI.
REQ-008 textO_vld  output  1  textO valid for exactly this cycle.

Function
REQ-009 Decryption SHALL be standard 32-round TEA decryption, all arithmetic modulo 2^32, shifts logical.
REQ-010 Round r (r=0..31) SHALL use sum_r = DELTA*(32-r) mod 2^32 (r=0 gives 32'hC6EF3720), computed as constants per stage.
REQ-011 Each round SHALL compute v1 -= ((v0<<4)+k2) ^ (v0+sum_r) ^ ((v0>>5)+k3), then, with the new v1, v0 -= ((v1<<4)+k0) ^ (v1+sum_r) ^ ((v1>>5)+k1).
REQ-012 The core SHALL be a 32-stage register pipeline, one full round per stage, with a valid bit travelling alongside each stage.
REQ-013 Throughput SHALL be one block per clock; a block is accepted on every rising edge where textI_vld=1, including back-to-back cycles.
REQ-014 Latency SHALL be 32 clocks: a block sampled at edge N appears on textO with textO_vld=1 after edge N+32.
REQ-015 Output order SHALL equal input order; gaps in textI_vld SHALL be reproduced as gaps in textO_vld.
REQ-016 When textI_vld=0 the stage data MAY update but its valid bit SHALL be 0; textO is don't-care while textO_vld=0.
REQ-017 key is used combinationally by every stage and SHALL be held stable while any block is in flight; a key change mid-flight gives undefined results for in-flight blocks only.

Reset
REQ-018 resetn=0 SHALL asynchronously clear all valid bits, textO_vld=0, and all data registers including textO to 0.
REQ-019 Blocks in flight when reset asserts SHALL be discarded and never emitted.
REQ-020 After resetn deasserts, the first textI_vld=1 sampled SHALL be processed normally; no warm-up cycles.

Configuration
REQ-021 Macro TEA_DEC_OUT_REG_EN: when defined, one extra output register stage is added after round 31, latency 33 clocks, all else unchanged.
REQ-022 Without TEA_DEC_OUT_REG_EN, latency SHALL be exactly 32 clocks per REQ-014.

Verification
REQ-023 key=0, textI=64'h41EA3A0A_94BAA940, one-cycle valid -> textO=64'h0, textO_vld=1 exactly 32 clocks later for one cycle.
REQ-024 Reset held 3 clocks, no input -> textO_vld stays 0, textO=0 throughout.
REQ-025 key=128'hABAB..AB, 100 consecutive-cycle blocks from a reference TEA encryptor -> 100 consecutive outputs equal the original plaintexts, in order.
REQ-026 Valid pattern 1,0,0,1,1,0,1 -> output valid pattern identical, shifted by 32 cycles, data correct.
REQ-027 Assert resetn=0 asynchronously (mid-cycle) with 10 blocks in flight -> textO_vld drops immediately; none of those blocks is emitted after release.
REQ-028 TEA_DEC_OUT_REG_EN defined, rerun REQ-023 -> identical output 33 clocks after input.
